// File: rtl/control_unit.sv
// Hardwired step sequencer for the Mini SRC CPU: fetch (T0-T2), execute (T3-T7),
// a divider wait state and halt. Opcode IR[31:27] is decoded from T3 onward.
module control_unit #(
  parameter logic [4:0] OP_ADD = 5'b00011
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic [31:0] IR,
  input  logic        calc_finished,
  input  logic        CON_output,
  input  logic        stop,
  output logic        clr,
  output logic        IncPC,
  output logic        Read,
  output logic        Write,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        BAout,
  output logic        CONin,
  output logic        reset_div,
  output logic        Rin,
  output logic        MDR_rd,
  output logic        MAR_rd,
  output logic        HI_rd,
  output logic        LO_rd,
  output logic        Zhi_rd,
  output logic        Zlo_rd,
  output logic        PC_rd,
  output logic        Out_rd,
  output logic        Y_rd,
  output logic        IR_rd,
  output logic        R_out,
  output logic        MDR_out,
  output logic        HI_out,
  output logic        LO_out,
  output logic        Zlo_out,
  output logic        Zhi_out,
  output logic        PC_out,
  output logic        In_out,
  output logic        C_out,
  output logic [4:0]  op_sel,
  output logic        run,
  output logic [3:0]  state_dbg
);

  typedef enum logic [3:0] {
    S_RST, S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_DIVW, S_HALT
  } state_t;

  typedef enum logic [4:0] {
    C_LD, C_LDI, C_ST, C_ALU, C_IMM, C_DIV, C_MUL, C_NEG, C_BR, C_JR,
    C_JAL, C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP, C_HALT
  } iclass_t;

  state_t      state;
  state_t      next_state;
  iclass_t     iclass;
  logic [4:0]  opcode;
  logic        unused_ir_bits;

  assign opcode         = IR[31:27];
  assign unused_ir_bits = ^IR[26:0];
  assign state_dbg      = state;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state <= S_RST;
    else        state <= next_state;
  end

  // Opcode to instruction class; undefined codes behave as nop.
  always_comb begin
    iclass = C_NOP;
    case (opcode)
      5'b00000: iclass = C_LD;
      5'b00001: iclass = C_LDI;
      5'b00010: iclass = C_ST;
      5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
      5'b01000, 5'b01001, 5'b01010, 5'b01011: iclass = C_ALU;
      5'b01100, 5'b01101, 5'b01110: iclass = C_IMM;
      5'b01111: iclass = C_DIV;
      5'b10000: iclass = C_MUL;
      5'b10001, 5'b10010: iclass = C_NEG;
      5'b10011: iclass = C_BR;
      5'b10100: iclass = C_JR;
      5'b10101: iclass = C_JAL;
      5'b10110: iclass = C_IN;
      5'b10111: iclass = C_OUT;
      5'b11000: iclass = C_MFHI;
      5'b11001: iclass = C_MFLO;
      5'b11011: iclass = C_HALT;
      default:  iclass = C_NOP;
    endcase
  end

  always_comb begin
    next_state = state;
    clr = 1'b0; IncPC = 1'b0; Read = 1'b0; Write = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; BAout = 1'b0; CONin = 1'b0;
    reset_div = 1'b0; Rin = 1'b0;
    MDR_rd = 1'b0; MAR_rd = 1'b0; HI_rd = 1'b0; LO_rd = 1'b0; Zhi_rd = 1'b0;
    Zlo_rd = 1'b0; PC_rd = 1'b0; Out_rd = 1'b0; Y_rd = 1'b0; IR_rd = 1'b0;
    R_out = 1'b0; MDR_out = 1'b0; HI_out = 1'b0; LO_out = 1'b0; Zlo_out = 1'b0;
    Zhi_out = 1'b0; PC_out = 1'b0; In_out = 1'b0; C_out = 1'b0;
    op_sel = 5'b00000;
    run = !(state == S_RST || state == S_IDLE || state == S_HALT);

    case (state)
      S_RST: begin
        clr        = 1'b1;
        next_state = S_T0;
      end
      S_IDLE: begin
        if (!stop) next_state = S_T0;
      end
      S_T0: begin
        if (stop) begin
          next_state = S_IDLE;
        end else begin
          PC_out = 1'b1; MAR_rd = 1'b1; IncPC = 1'b1;
          next_state = S_T1;
        end
      end
      S_T1: begin
        Read = 1'b1; MDR_rd = 1'b1;
        next_state = S_T2;
      end
      S_T2: begin
        MDR_out = 1'b1; IR_rd = 1'b1;
        next_state = S_T3;
      end
      S_T3: begin
        next_state = S_T4;
        case (iclass)
          C_ALU, C_IMM: begin Grb = 1'b1; R_out = 1'b1; Y_rd = 1'b1; end
          C_NEG: begin
            Grb = 1'b1; R_out = 1'b1; Zlo_rd = 1'b1; op_sel = opcode;
          end
          C_MUL, C_DIV: begin Gra = 1'b1; R_out = 1'b1; Y_rd = 1'b1; end
          C_LD, C_LDI, C_ST: begin Grb = 1'b1; BAout = 1'b1; Y_rd = 1'b1; end
          C_BR: begin Gra = 1'b1; R_out = 1'b1; CONin = 1'b1; end
          C_JAL: begin PC_out = 1'b1; Grb = 1'b1; Rin = 1'b1; end
          C_JR: begin
            Gra = 1'b1; R_out = 1'b1; PC_rd = 1'b1; next_state = S_T0;
          end
          C_IN: begin
            In_out = 1'b1; Gra = 1'b1; Rin = 1'b1; next_state = S_T0;
          end
          C_OUT: begin
            Gra = 1'b1; R_out = 1'b1; Out_rd = 1'b1; next_state = S_T0;
          end
          C_MFHI: begin
            HI_out = 1'b1; Gra = 1'b1; Rin = 1'b1; next_state = S_T0;
          end
          C_MFLO: begin
            LO_out = 1'b1; Gra = 1'b1; Rin = 1'b1; next_state = S_T0;
          end
          C_HALT:  next_state = S_HALT;
          default: next_state = S_T0;
        endcase
      end
      S_T4: begin
        next_state = S_T5;
        case (iclass)
          C_ALU: begin
            Grc = 1'b1; R_out = 1'b1; Zlo_rd = 1'b1; op_sel = opcode;
          end
          C_IMM: begin C_out = 1'b1; Zlo_rd = 1'b1; op_sel = opcode; end
          C_NEG: begin
            Zlo_out = 1'b1; Gra = 1'b1; Rin = 1'b1; next_state = S_T0;
          end
          C_MUL: begin
            Grb = 1'b1; R_out = 1'b1; Zhi_rd = 1'b1; Zlo_rd = 1'b1;
            op_sel = opcode;
          end
          C_DIV: begin
            Grb = 1'b1; R_out = 1'b1; reset_div = 1'b1; op_sel = opcode;
            next_state = S_DIVW;
          end
          C_LD, C_LDI, C_ST: begin C_out = 1'b1; Zlo_rd = 1'b1; op_sel = OP_ADD; end
          C_BR: begin PC_out = 1'b1; Y_rd = 1'b1; end
          C_JAL: begin
            Gra = 1'b1; R_out = 1'b1; PC_rd = 1'b1; next_state = S_T0;
          end
          default: next_state = S_T0;
        endcase
      end
      // Operands stay on the bus until the divider reports completion.
      S_DIVW: begin
        Grb = 1'b1; R_out = 1'b1; op_sel = opcode;
        if (calc_finished) begin
          Zhi_rd = 1'b1; Zlo_rd = 1'b1;
          next_state = S_T5;
        end
      end
      S_T5: begin
        next_state = S_T0;
        case (iclass)
          C_ALU, C_IMM, C_LDI: begin Zlo_out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          C_MUL, C_DIV: begin Zlo_out = 1'b1; LO_rd = 1'b1; next_state = S_T6; end
          C_LD, C_ST: begin Zlo_out = 1'b1; MAR_rd = 1'b1; next_state = S_T6; end
          C_BR: begin
            C_out = 1'b1; Zlo_rd = 1'b1; op_sel = OP_ADD; next_state = S_T6;
          end
          default: next_state = S_T0;
        endcase
      end
      S_T6: begin
        next_state = S_T0;
        case (iclass)
          C_MUL, C_DIV: begin Zhi_out = 1'b1; HI_rd = 1'b1; end
          C_LD: begin Read = 1'b1; MDR_rd = 1'b1; next_state = S_T7; end
          C_ST: begin Gra = 1'b1; R_out = 1'b1; MDR_rd = 1'b1; next_state = S_T7; end
          C_BR: begin
            if (CON_output) begin Zlo_out = 1'b1; PC_rd = 1'b1; end
          end
          default: next_state = S_T0;
        endcase
      end
      S_T7: begin
        next_state = S_T0;
        case (iclass)
          C_LD:    begin MDR_out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          C_ST:    Write = 1'b1;
          default: next_state = S_T0;
        endcase
      end
      S_HALT:  next_state = S_HALT;
      default: next_state = S_RST;
    endcase
  end

endmodule

// File: doc/control_unit.md
# control_unit

Hardwired control sequencer for the Mini SRC CPU. It is the driving end of the datapath control interface: each cycle it takes the instruction-register contents plus the `calc_finished` and `CON_output` status lines, and produces every datapath enable, select and memory strobe. It is a Moore-style step FSM covering fetch, execute, a divider wait state, and halt. It sits between the top-level CPU wrapper and the datapath.

## Interface
Parameters:
- `OP_ADD`, 5'b00011: op_sel code used for address and branch-target adds.

Ports:
- `clk` in 1: system clock, rising edge.
- `clr_n` in 1: asynchronous, active-low reset.
- `IR` in 32: datapath IR contents. Opcode is `IR[31:27]`.
- `calc_finished` in 1: divider done.
- `CON_output` in 1: branch condition flip-flop.
- `stop` in 1: hold the CPU in IDLE at the next fetch boundary.
- `clr` out 1: synchronous clear to the datapath.
- `IncPC`, `Read`, `Write`, `Gra`, `Grb`, `Grc`, `BAout`, `CONin`, `reset_div`, `Rin` out 1 each: datapath controls.
- `MDR_rd`, `MAR_rd`, `HI_rd`, `LO_rd`, `Zhi_rd`, `Zlo_rd`, `PC_rd`, `Out_rd`, `Y_rd`, `IR_rd` out 1 each: register loads.
- `R_out`, `MDR_out`, `HI_out`, `LO_out`, `Zlo_out`, `Zhi_out`, `PC_out`, `In_out`, `C_out` out 1 each: bus drivers.
- `op_sel` out 5: ALU operation select.
- `run` out 1: high unless in RST, IDLE or HALT.

## Operation
- Any signal not listed for a step is 0. During each step, at most one `*_out` bus driver is high.
- In ALU steps, `op_sel` equals `IR[31:27]`. In address and branch steps it is `OP_ADD`. Otherwise it is 0.
- States: RST, IDLE, T0–T7, DIVW, HALT.

Fetch:
- RST: `clr`=1. Next state is T0.
- T0: if `stop`=1, next state is IDLE. Otherwise assert `PC_out`, `MAR_rd`, `IncPC`.
- IDLE: all outputs 0. Returns to T0 when `stop`=0.
- T1: `Read`, `MDR_rd`.
- T2: `MDR_out`, `IR_rd`.

Execute (T3 onward). Each instruction returns to T0 after its last listed step:
- add/sub/and/or/ror/rol/shr/shra/shl (00011–01011):
  - T3: `Grb` `R_out` `Y_rd`.
  - T4: `Grc` `R_out` `Zlo_rd`.
  - T5: `Zlo_out` `Gra` `Rin`.
- addi/andi/ori (01100–01110): as above, but T4 uses `C_out` in place of `Grc` `R_out`.
- neg/not (10001, 10010):
  - T3: `Grb` `R_out` `Zlo_rd`.
  - T4: `Zlo_out` `Gra` `Rin`.
- mul (10000):
  - T3: `Gra` `R_out` `Y_rd`.
  - T4: `Grb` `R_out` `Zhi_rd` `Zlo_rd`.
  - T5: `Zlo_out` `LO_rd`.
  - T6: `Zhi_out` `HI_rd`.
- div (01111):
  - T3: `Gra` `R_out` `Y_rd`.
  - T4: `Grb` `R_out` `reset_div`.
  - DIVW: hold `Grb` `R_out` and op_sel. In the cycle where `calc_finished`=1, also assert `Zhi_rd` `Zlo_rd` and go to T5.
  - T5 and T6: same as mul.
- ld/ldi/st (00000/00001/00010):
  - T3: `Grb` `BAout` `Y_rd`.
  - T4: `C_out` `Zlo_rd`.
  - ldi T5: `Zlo_out` `Gra` `Rin`.
  - ld T5: `Zlo_out` `MAR_rd`.
  - ld T6: `Read` `MDR_rd`.
  - ld T7: `MDR_out` `Gra` `Rin`.
  - st T5: same as ld.
  - st T6: `Gra` `R_out` `MDR_rd` (`Read`=0).
  - st T7: `Write`.
- br (10011):
  - T3: `Gra` `R_out` `CONin`.
  - T4: `PC_out` `Y_rd`.
  - T5: `C_out` `Zlo_rd`.
  - T6: if `CON_output`=1, assert `Zlo_out` `PC_rd`. Otherwise no signals.
- jr (10100): T3: `Gra` `R_out` `PC_rd`.
- jal (10101):
  - T3: `PC_out` `Grb` `Rin`.
  - T4: `Gra` `R_out` `PC_rd`.
- in (10110): T3: `In_out` `Gra` `Rin`.
- out (10111): T3: `Gra` `R_out` `Out_rd`.
- mfhi (11000): T3: `HI_out` `Gra` `Rin`.
- mflo (11001): T3: `LO_out` `Gra` `Rin`.
- nop (11010) and the undefined opcodes 11100–11111: T3 with no signals.
- halt (11011): go to HALT. All outputs stay 0 until `clr_n` is low.

## Timing
- While `clr_n`=0, state is RST and `clr`=1, all other outputs 0, `run`=0. After release, `clr` stays high for exactly one more cycle, then T0.
- Reset asserted mid-instruction, including in DIVW, aborts immediately. No `Write` pulse may follow.
- State changes on the rising edge of `clk`. Outputs are decoded from state, except three Mealy terms:
  - DIVW `Zhi_rd`/`Zlo_rd`, which depend on `calc_finished`.
  - br T6 `PC_rd`, which depends on `CON_output`.
  - T0, which depends on `stop`.
- `IR` is decoded only in T3 and later. The IR loads at the end of T2.
- Latency in cycles, including fetch:
  - ALU reg-reg: 6.
  - Immediate: 6.
  - neg/not: 5.
  - mul: 7.
  - div: 7 + (number of DIVW cycles).
  - ld: 8. ldi: 6. st: 8.
  - br: 7.
  - jr/in/out/mfhi/mflo/nop: 4.
  - jal: 5.
- `calc_finished` already high on DIVW entry: DIVW lasts exactly 1 cycle.
- `stop` rising mid-instruction: the instruction completes first, then IDLE.

## Test plan
- Reset held 3 cycles, then released → `clr`=1 for 4 cycles total, then T0 with `PC_out`=`MAR_rd`=`IncPC`=1, `run`=1.
- `IR`=0x18918000 (add r1,r2,r3) → T3 `Y_rd`, T4 `Zlo_rd` with op_sel=00011, T5 `Rin`, T0 at cycle 6.
- `IR`=0x00800005 (ld r1,5(r0)) → T3 `BAout`, T4 op_sel=00011, T6 `Read`, T7 `MDR_out`+`Rin`. Total 8 cycles.
- div with `calc_finished` rising 33 cycles after T4 → `reset_div` exactly one cycle, `Zhi_rd`/`Zlo_rd` only in the done cycle, `HI_rd` 2 cycles later.
- br with `CON_output`=0, then =1 → T6 has no signals in the first case; `PC_rd`+`Zlo_out` in the second.
- halt, then `clr_n` low in HALT → all outputs 0 and `run`=0 while halted; restart via RST. Also: `stop`=1 during st T7 → `Write` still pulses, then IDLE.
